// File: rtl/riscv_defs.sv
// Shared RV32 definitions for the writeback slice: datapath width, WB source codes, load funct3 codes.
// No logic, so no latency.
// No handshake; constants only.
package riscv_defs;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Extracts and extends the addressed byte/halfword lane of a 32-bit memory read word.
// Purely combinational, zero cycles.
// No handshake; follows its inputs.
module load_align
  import riscv_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select; a misaligned halfword simply uses off[1] and ignores off[0].
  always_comb begin
    byte_lane = 8'(rdata >> {off, 3'b000});
    half_lane = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      FUNCT3_LB:  data = {{24{byte_lane[7]}}, byte_lane};
      FUNCT3_LBU: data = {24'd0, byte_lane};
      FUNCT3_LH:  data = {{16{half_lane[15]}}, half_lane};
      FUNCT3_LHU: data = {16'd0, half_lane};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// MEM/WB register plus writeback: selects source, drives RegFile write port, bypass hits, retire counter.
// Instruction captured at edge N drives rf_we during cycle N; RegFile commits at edge N+1.
// stall holds the WB register; a stalled instruction writes once and is retired at its release edge.
module regfile_writeback
  import riscv_defs::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_reg_write,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_pc_plus4,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [4:0]       ex_ra1,
  input  logic [4:0]       ex_ra2,
  output logic             rf_we,
  output logic [4:0]       rf_wa,
  output logic [XLEN-1:0]  rf_wd,
  output logic             fwd1_hit,
  output logic             fwd2_hit,
  output logic             wb_is_load,
  output logic [CNT_W-1:0] instret
);

  logic            wb_valid;
  logic            wb_reg_write;
  logic [4:0]      wb_rd;
  logic [1:0]      wb_sel;
  logic [2:0]      wb_funct3;
  logic [XLEN-1:0] wb_alu_result;
  logic [XLEN-1:0] wb_pc_plus4;
  logic            done;
  logic            wr_cond;
  logic [31:0]     load_data;

  load_align u_load_align (
    .rdata  (mem_rdata[31:0]),
    .off    (wb_alu_result[1:0]),
    .funct3 (wb_funct3),
    .data   (load_data)
  );

  // WB register, write-once flag and retire counter; stall has priority over flush.
  // done only suppresses repeat writes; retirement is counted once, at the first non-stalled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= 5'd0;
      wb_sel        <= WB_SEL_ALU;
      wb_funct3     <= 3'd0;
      wb_alu_result <= '0;
      wb_pc_plus4   <= '0;
      done          <= 1'b0;
      instret       <= '0;
    end else begin
      if (stall) begin
        if (wr_cond) done <= 1'b1;
      end else begin
        wb_valid      <= in_valid & ~flush;
        wb_reg_write  <= in_reg_write;
        wb_rd         <= in_rd;
        wb_sel        <= in_wb_sel;
        wb_funct3     <= in_funct3;
        wb_alu_result <= in_alu_result;
        wb_pc_plus4   <= in_pc_plus4;
        done          <= 1'b0;
      end
      if (wb_valid && !stall) instret <= instret + 1'b1;
    end
  end

  // Write port, source mux (reserved code falls back to ALU), bypass compares.
  always_comb begin
    wr_cond = wb_valid & wb_reg_write & (wb_rd != 5'd0) & ~done;
    rf_we   = wr_cond;
    rf_wa   = wb_rd;
    case (wb_sel)
      WB_SEL_MEM: rf_wd = XLEN'(load_data);
      WB_SEL_PC4: rf_wd = wb_pc_plus4;
      default:    rf_wd = wb_alu_result;
    endcase
    fwd1_hit   = wr_cond & (ex_ra1 == wb_rd);
    fwd2_hit   = wr_cond & (ex_ra2 == wb_rd);
    wb_is_load = wb_valid & (wb_sel == WB_SEL_MEM);
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: expected writes go into a scoreboard queue, a negedge monitor checks them.
// Direct checks cover reset state, bypass hits, stall/flush behaviour and the retire counter.
// A small RegFile model confirms commits one edge after rf_we.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, in_valid, in_reg_write;
  logic [4:0]  in_rd, ex_ra1, ex_ra2;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_pc_plus4, mem_rdata;
  logic        rf_we, fwd1_hit, fwd2_hit, wb_is_load;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, instret;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic [36:0] exp_q[$];
  logic [31:0] rf_model [32];

  regfile_writeback #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4), .mem_rdata(mem_rdata),
    .ex_ra1(ex_ra1), .ex_ra2(ex_ra2), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .wb_is_load(wb_is_load), .instret(instret)
  );

  always #5 clk = ~clk;

  // Minimal RegFile model fed by the write port.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_model[i] <= 32'd0;
    end else if (rf_we) begin
      rf_model[rf_wa] <= rf_wd;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      logic [36:0] e;
      n_writes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got wa=%0d wd=%h expected no write", rf_wa, rf_wd);
      end else begin
        e = exp_q.pop_front();
        if ({rf_wa, rf_wd} !== e) begin
          n_fail++;
          $display("FAIL wb_write: got wa=%0d wd=%h expected wa=%0d wd=%h", rf_wa, rf_wd, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] wd);
    exp_q.push_back({rd, wd});
  endtask

  // Present one valid instruction for a single edge, then bubble; returns during its WB cycle.
  task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
    in_valid = 1'b1; in_reg_write = rw; in_rd = rd; in_wb_sel = sel;
    in_funct3 = f3; in_alu_result = alu; in_pc_plus4 = pc4;
    tick();
    in_valid = 1'b0;
  endtask

  logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [31:0] ld_off [5] = '{32'd3, 32'd0, 32'd2, 32'd1, 32'd0};
  logic [31:0] ld_exp [5] = '{32'hFFFFFF8B, 32'h0000000D, 32'hFFFF8BAD, 32'h0000F00D, 32'h8BADF00D};

  initial begin
    int w0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0;
    in_rd = 5'd0; in_wb_sel = 2'd0; in_funct3 = 3'd0; in_alu_result = 32'd0;
    in_pc_plus4 = 32'd0; mem_rdata = 32'd0; ex_ra1 = 5'd0; ex_ra2 = 5'd0;
    tick(); tick();
    check("reset_rf_we", rf_we, 0);
    check("reset_rf_wa", rf_wa, 0);
    check("reset_rf_wd", rf_wd, 0);
    check("reset_fwd", {fwd1_hit, fwd2_hit}, 0);
    check("reset_is_load", wb_is_load, 0);
    check("reset_instret", instret, 0);
    rst_n = 1'b1;

    // ALU write to x3
    push(5'd3, 32'hFEEDABBA);
    issue(1'b1, 5'd3, 2'b00, 3'd0, 32'hFEEDABBA, 32'd0);
    check("alu_rf_we", rf_we, 1);
    tick();
    check("alu_commit", rf_model[3], 32'hFEEDABBA);
    check("alu_instret", instret, 1);

    // x0 write is suppressed but still retires
    issue(1'b1, 5'd0, 2'b00, 3'd0, 32'hFFFFFFFF, 32'd0);
    check("x0_rf_we", rf_we, 0);
    check("x0_fwd", {fwd1_hit, fwd2_hit}, 0);
    tick();
    check("x0_reg0", rf_model[0], 0);
    check("x0_instret", instret, 2);

    // Load alignment, back to back
    mem_rdata = 32'h8badf00d;
    for (int i = 0; i < 5; i++) begin
      push(5'(10 + i), ld_exp[i]);
      issue(1'b1, 5'(10 + i), 2'b01, ld_f3[i], ld_off[i], 32'd0);
      check("load_is_load", wb_is_load, 1);
    end
    tick();
    check("load_instret", instret, 7);
    check("load_commit_lw", rf_model[14], 32'h8BADF00D);

    // Stalled load writes once with first-cycle data
    mem_rdata = 32'h11223344;
    push(5'd5, 32'h11223344);
    w0 = n_writes;
    issue(1'b1, 5'd5, 2'b01, 3'b010, 32'd0, 32'd0);
    stall = 1'b1;
    tick();
    mem_rdata = 32'hDEADBEEF;
    check("stall_no_rewrite", rf_we, 0);
    check("stall_is_load", wb_is_load, 1);
    tick(); tick();
    stall = 1'b0;
    check("stall_release_we", rf_we, 0);
    tick();
    check("stall_one_write", n_writes - w0, 1);
    check("stall_instret", instret, 8);
    check("stall_commit", rf_model[5], 32'h11223344);

    // Flush squashes: no write, no count
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd9; in_wb_sel = 2'b00; in_alu_result = 32'h1234;
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_rf_we", rf_we, 0);
    tick();
    check("flush_instret", instret, 8);

    // Forwarding to both operands, then PC+4, reserved sel and a non-writing instruction
    ex_ra1 = 5'd7; ex_ra2 = 5'd7;
    push(5'd7, 32'h10838234);
    issue(1'b1, 5'd7, 2'b00, 3'd0, 32'h10838234, 32'd0);
    check("fwd_both", {fwd1_hit, fwd2_hit}, 2'b11);
    check("fwd_wd", rf_wd, 32'h10838234);
    ex_ra2 = 5'd6;
    #1;
    check("fwd_one", {fwd1_hit, fwd2_hit}, 2'b10);
    push(5'd1, 32'h00400004);
    issue(1'b1, 5'd1, 2'b10, 3'd0, 32'h13, 32'h00400004);
    push(5'd4, 32'hCAFEF00D);
    issue(1'b1, 5'd4, 2'b11, 3'd0, 32'hCAFEF00D, 32'h1111);
    issue(1'b0, 5'd7, 2'b00, 3'd0, 32'h5555, 32'd0);
    check("nowrite_fwd", fwd1_hit, 0);
    tick();
    check("mix_instret", instret, 12);
    ex_ra1 = 5'd0; ex_ra2 = 5'd0;

    // Reset in the middle of a stalled write
    issue(1'b1, 5'd6, 2'b00, 3'd0, 32'hAAAA5555, 32'd0);
    stall = 1'b1;
    check("prereset_rf_we", rf_we, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rf_we", rf_we, 0);
    check("async_instret", instret, 0);
    check("async_rf_wa", rf_wa, 0);
    tick(); tick();
    rst_n = 1'b1; stall = 1'b0;
    push(5'd2, 32'h0BADCAFE);
    issue(1'b1, 5'd2, 2'b00, 3'd0, 32'h0BADCAFE, 32'd0);
    tick();
    check("postreset_commit", rf_model[2], 32'h0BADCAFE);
    check("postreset_instret", instret, 1);
    check("scoreboard_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

endmodule
